// File: rtl/chunk_sched_pkg.sv
// Shared types and constants for the chunk-hashing engine scheduler.
package chunk_sched_pkg;

    localparam int MAX_CHUNK_BYTES = 1024;
    localparam int BLOCK_BYTES     = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_ABORT
    } sched_state_t;

    // Why a job left RUN early; selects the Err/Clear pulses in ABORT.
    typedef enum logic [1:0] {
        AB_LEN,
        AB_TMO,
        AB_DROP
    } abort_cause_t;

    function automatic logic len_ok(input logic [10:0] n);
        return (n != 11'd0) && (n <= 11'(MAX_CHUNK_BYTES));
    endfunction

endpackage

// File: rtl/chunk_scheduler_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (!vld_o && req_i[(int'(ptr_i) + i) % N]) begin
                vld_o = 1'b1;
                idx_o = IW'((int'(ptr_i) + i) % N);
            end
        end
        gnt_o = vld_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/chunk_scheduler.sv
// Shares one chunk-hashing engine among NUM_REQ requesters, one job at a time,
// with bad-length rejection, hung-job timeout and request-drop abort.
module chunk_scheduler
    import chunk_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic [NUM_REQ-1:0]                Req_I,
    input  logic [NUM_REQ-1:0][10:0]          ByteNum_I,
    input  logic [NUM_REQ-1:0][15:0][31:0]    Msg_I,
    output logic [NUM_REQ-1:0]                Gnt_O,
    output logic [NUM_REQ-1:0]                MsgNext_O,
    output logic [NUM_REQ-1:0]                Done_O,
    output logic [NUM_REQ-1:0]                Err_O,
    output logic [7:0][31:0]                  H_O,
    output logic                              HUpdate_O,
    output logic                              HClear_O,
    output logic [10:0]                       HByteNum_O,
    output logic [15:0][31:0]                 HMsg_O,
    input  logic                              HNext_I,
    input  logic                              HVld_I,
    input  logic [7:0][31:0]                  HH_I
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    sched_state_t         state_q, state_d;
    abort_cause_t         cause_q, cause_d;
    logic [IW-1:0]        gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tmo_q, tmo_d;
    logic [7:0][31:0]     h_q, h_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_vld;
    logic [NUM_REQ-1:0]   gnt_oh;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req_i (Req_I),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tmo_d     = 1'b0;
        h_d       = h_q;
        case (state_q)
            S_IDLE: begin
                if (arb_vld) begin
                    gnt_idx_d = arb_idx;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!len_ok(ByteNum_I[gnt_idx_q])) begin
                    cause_d = AB_LEN;
                    state_d = S_ABORT;
                end else begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Counter saturates; expiry is registered, so the abort lands
                // one cycle after the counter reaches its last value.
                if (cnt_q != CW'(TIMEOUT - 1)) cnt_d = cnt_q + CW'(1);
                tmo_d = (cnt_q == CW'(TIMEOUT - 1));
                if (HVld_I) begin
                    h_d     = HH_I;
                    state_d = S_DONE;
                end else if (tmo_q) begin
                    cause_d = AB_TMO;
                    state_d = S_ABORT;
                end else if (!Req_I[gnt_idx_q]) begin
                    cause_d = AB_DROP;
                    state_d = S_ABORT;
                end
            end
            S_DONE, S_ABORT: begin
                ptr_d   = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cause_q   <= AB_LEN;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
            h_q       <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            h_q       <= h_d;
        end
    end

    always_comb begin
        gnt_oh     = (state_q != S_IDLE) ? (NUM_REQ'(1) << gnt_idx_q) : '0;
        Gnt_O      = gnt_oh;
        MsgNext_O  = (state_q == S_RUN && HNext_I) ? gnt_oh : '0;
        Done_O     = (state_q == S_DONE) ? gnt_oh : '0;
        Err_O      = (state_q == S_ABORT && cause_q != AB_DROP) ? gnt_oh : '0;
        HUpdate_O  = (state_q == S_LAUNCH) && len_ok(ByteNum_I[gnt_idx_q]);
        HClear_O   = (state_q == S_ABORT) && (cause_q != AB_LEN);
        HMsg_O     = (state_q != S_IDLE) ? Msg_I[gnt_idx_q] : '0;
        HByteNum_O = (state_q != S_IDLE) ? ByteNum_I[gnt_idx_q] : '0;
        H_O        = h_q;
    end

endmodule

// File: tb/tb_chunk_scheduler.sv
// Directed bench for chunk_scheduler: one instance at the default timeout and
// one with TIMEOUT=16 for the timeout/collision corners, sharing stimulus.
module tb_chunk_scheduler;

    logic                 Clk;
    logic                 Rst;
    logic [3:0]           req;
    logic [3:0][10:0]     bn;
    logic [3:0][15:0][31:0] msg;
    logic                 hnext, hvld;
    logic [7:0][31:0]     hh;

    logic [3:0]           gnt, mnext, done, err;
    logic [7:0][31:0]     h;
    logic                 hupd, hclr;
    logic [10:0]          hbn;
    logic [15:0][31:0]    hmsg;

    logic [3:0]           gnt_t, mnext_t, done_t, err_t;
    logic [7:0][31:0]     h_t;
    logic                 hupd_t, hclr_t;
    logic [10:0]          hbn_t;
    logic [15:0][31:0]    hmsg_t;

    int n_tests = 0;
    int n_fail  = 0;

    chunk_scheduler #(.NUM_REQ(4)) dut (
        .Clk(Clk), .Rst(Rst), .Req_I(req), .ByteNum_I(bn), .Msg_I(msg),
        .Gnt_O(gnt), .MsgNext_O(mnext), .Done_O(done), .Err_O(err), .H_O(h),
        .HUpdate_O(hupd), .HClear_O(hclr), .HByteNum_O(hbn), .HMsg_O(hmsg),
        .HNext_I(hnext), .HVld_I(hvld), .HH_I(hh)
    );

    chunk_scheduler #(.NUM_REQ(4), .TIMEOUT(16)) dut16 (
        .Clk(Clk), .Rst(Rst), .Req_I(req), .ByteNum_I(bn), .Msg_I(msg),
        .Gnt_O(gnt_t), .MsgNext_O(mnext_t), .Done_O(done_t), .Err_O(err_t), .H_O(h_t),
        .HUpdate_O(hupd_t), .HClear_O(hclr_t), .HByteNum_O(hbn_t), .HMsg_O(hmsg_t),
        .HNext_I(hnext), .HVld_I(hvld), .HH_I(hh)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is in an IDLE cycle with req already driven; returns in the IDLE
    // cycle after Done, two cycles after the engine's valid.
    task automatic run_job(input int idx, input int lat, input logic [255:0] hv);
        logic [3:0] oh;
        int upd_n;
        int dn_n;
        oh = 4'b0001 << idx;
        tick();
        chk("launch_gnt", 512'(gnt), 512'(oh));
        chk("launch_bn", 512'(hbn), 512'(bn[idx]));
        chk("launch_msg", 512'(hmsg), 512'(msg[idx]));
        upd_n = int'(hupd);
        dn_n  = 0;
        for (int k = 1; k <= lat; k++) begin
            tick();
            upd_n += int'(hupd);
            dn_n  += int'(done != 4'b0000) + int'(err != 4'b0000);
        end
        chk("run_gnt_held", 512'(gnt), 512'(oh));
        chk("upd_once", 512'(upd_n), 512'(1));
        chk("no_early_done", 512'(dn_n), 512'(0));
        hvld = 1'b1;
        hh   = hv;
        tick();
        hvld = 1'b0;
        chk("done", 512'(done), 512'(oh));
        chk("done_h", 512'(h), 512'(hv));
        chk("done_no_err", 512'(err), 512'(0));
        tick();
        chk("gnt_released", 512'(gnt), 512'(0));
    endtask

    initial begin
        int nx_n;
        logic [3:0] fair_exp [8];
        fair_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        Rst   = 1'b1;
        req   = '0;
        hnext = 1'b0;
        hvld  = 1'b0;
        hh    = '0;
        for (int i = 0; i < 4; i++) begin
            bn[i] = 11'd64;
            for (int w = 0; w < 16; w++) msg[i][w] = {8'(i), 8'(w), 16'hC0DE};
        end
        tick();
        tick();
        chk("rst_gnt", 512'(gnt), 512'(0));
        chk("rst_done_err", 512'({done, err}), 512'(0));
        chk("rst_upd_clr", 512'({hupd, hclr}), 512'(0));
        chk("rst_h", 512'(h), 512'(0));
        chk("rst_mux", 512'({hbn, hmsg}), 512'(0));
        Rst = 1'b0;

        // Single job on requester 0, engine valid 71 cycles after update
        req = 4'b0001;
        run_job(0, 71, {8{32'h1111_0001}});

        // Fairness: ptr now 1, all four held high
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("fair_gnt", 512'(gnt), 512'(fair_exp[j]));
            repeat (2 + j) tick();
            hvld = 1'b1;
            hh   = {8{32'h2200_0000 + 32'(j)}};
            tick();
            hvld = 1'b0;
            chk("fair_done", 512'(done), 512'(fair_exp[j]));
            chk("fair_h", 512'(h), 512'({8{32'h2200_0000 + 32'(j)}}));
            tick();
        end
        req = 4'b0000;
        tick();

        // Multi-block: 1024 bytes on requester 2, 15 next-block requests
        req   = 4'b0100;
        bn[2] = 11'd1024;
        tick();
        chk("mb_gnt", 512'(gnt), 512'(4'b0100));
        chk("mb_bn", 512'(hbn), 512'(11'd1024));
        chk("mb_upd", 512'(hupd), 512'(1'b1));
        nx_n = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            hnext = 1'b1;
            msg[2][0] = 32'hB000_0000 + 32'(k);
            #1;
            nx_n += int'(mnext == 4'b0100);
            chk("mb_msg", 512'(hmsg), 512'(msg[2]));
        end
        tick();
        hnext = 1'b0;
        hvld  = 1'b1;
        hh    = {8{32'h3333_0003}};
        #1;
        chk("mb_next_cnt", 512'(nx_n), 512'(15));
        chk("mb_next_idle", 512'(mnext), 512'(0));
        tick();
        hvld = 1'b0;
        req  = 4'b0000;
        chk("mb_done", 512'(done), 512'(4'b0100));
        tick();
        bn[2] = 11'd64;

        // Bad lengths: Err at t+2, no update, no clear
        for (int b = 0; b < 2; b++) begin
            bn[0] = (b == 0) ? 11'd0 : 11'd1025;
            req   = 4'b0001;
            tick();
            chk("bad_gnt", 512'(gnt), 512'(4'b0001));
            chk("bad_no_upd", 512'(hupd), 512'(1'b0));
            tick();
            chk("bad_err", 512'(err), 512'(4'b0001));
            chk("bad_no_clr", 512'(hclr), 512'(1'b0));
            chk("bad_no_done", 512'(done), 512'(0));
            req = 4'b0000;
            tick();
            chk("bad_release", 512'(gnt), 512'(0));
        end
        bn[0] = 11'd64;

        // Request dropped during RUN: clear only
        req = 4'b0010;
        tick();
        tick();
        tick();
        req = 4'b0000;
        tick();
        chk("drop_clr", 512'(hclr), 512'(1'b1));
        chk("drop_no_err_done", 512'({err, done}), 512'(0));
        tick();
        chk("drop_release", 512'(gnt), 512'(0));

        Rst = 1'b1;
        tick();
        Rst = 1'b0;

        // Timeout on the TIMEOUT=16 instance: Err/Clear 18 cycles after update
        req = 4'b0001;
        tick();
        chk("tmo_upd", 512'(hupd_t), 512'(1'b1));
        repeat (17) tick();
        chk("tmo_not_yet", 512'({err_t, hclr_t}), 512'(0));
        tick();
        chk("tmo_err", 512'(err_t), 512'(4'b0001));
        chk("tmo_clr", 512'(hclr_t), 512'(1'b1));
        chk("tmo_no_done", 512'(done_t), 512'(0));
        req = 4'b0000;
        tick();
        chk("tmo_release", 512'(gnt_t), 512'(0));

        // Valid on the last timeout cycle wins
        req = 4'b0010;
        tick();
        chk("col_gnt", 512'(gnt_t), 512'(4'b0010));
        repeat (17) tick();
        hvld = 1'b1;
        hh   = {8{32'h5555_0005}};
        tick();
        hvld = 1'b0;
        req  = 4'b0000;
        chk("col_done", 512'(done_t), 512'(4'b0010));
        chk("col_no_err", 512'({err_t, hclr_t}), 512'(0));
        chk("col_h", 512'(h_t), 512'({8{32'h5555_0005}}));
        repeat (3) tick();

        // Asynchronous reset in the middle of RUN
        req = 4'b0100;
        tick();
        tick();
        tick();
        hnext = 1'b1;
        Rst   = 1'b1;
        #1;
        chk("arst_gnt", 512'({gnt, gnt_t}), 512'(0));
        chk("arst_pulses", 512'({mnext, done, err, hupd, hclr}), 512'(0));
        chk("arst_mux", 512'({hbn, hmsg}), 512'(0));
        chk("arst_h", 512'({h, h_t}), 512'(0));
        hnext = 1'b0;
        tick();
        Rst = 1'b0;
        req = 4'b0101;
        tick();
        chk("arst_ptr0", 512'(gnt), 512'(4'b0001));
        chk("arst_ptr0_t", 512'(gnt_t), 512'(4'b0001));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
